step_tracker: RTL and testbench

Activity-statistics stage directly upstream of outputSelector. It counts rising edges of the step pulse stream and maintains four 14-bit statistics: total steps, distance, early high-rate seconds and sustained high-rate seconds. These drive outputSelector's totalSteps, distanceCovered, thirtyTwoStepsPerSecond and sixtyFourStepsPerSecond inputs directly. All outputs are registered.

---
 rtl/step_tracker.sv | 137 +++++++++++++
 tb/tb_step_tracker.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/step_tracker.sv
// Step statistics: edge-counted steps, distance and per-second rate tallies.
// All outputs are registered and saturate at the four-digit display limit.
module step_tracker #(
    parameter int CLK_HZ              = 100000000,
    parameter int STEPS_PER_HALF_MILE = 1024,
    parameter int EARLY_SECONDS       = 9,
    parameter int SAT_MAX             = 9999
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        stepIn,
    output logic [13:0] totalSteps,
    output logic [13:0] distanceCovered,
    output logic [13:0] thirtyTwoStepsPerSecond,
    output logic [13:0] sixtyFourStepsPerSecond,
    output logic        secondTick
);

    localparam int WW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int HW = $clog2(STEPS_PER_HALF_MILE);

    localparam logic [WW-1:0] WIN_LAST = WW'(CLK_HZ - 1);
    localparam logic [13:0]   SAT      = 14'(SAT_MAX);
    localparam logic [3:0]    EARLY    = 4'(EARLY_SECONDS);
    localparam logic [7:0]    RATE_LO  = 8'd32;
    localparam logic [7:0]    RATE_HI  = 8'd64;

    logic          step_prev_q,  step_prev_d;
    logic [WW-1:0] window_cnt_q, window_cnt_d;
    logic          second_tick_q, second_tick_d;
    logic [7:0]    per_sec_q,    per_sec_d;
    logic [HW-1:0] half_sub_q,   half_sub_d;
    logic [3:0]    elapsed_q,    elapsed_d;
    logic [13:0]   total_q,      total_d;
    logic [13:0]   dist_q,       dist_d;
    logic [13:0]   early_q,      early_d;
    logic [13:0]   fast_q,       fast_d;

    logic          step_evt;
    logic          window_end;
    logic          half_wrap;
    logic [7:0]    per_sec_inc;
    logic [7:0]    n_final;

    // Event detection and the free-running one-second window
    always_comb begin
        step_evt      = stepIn & ~step_prev_q;
        step_prev_d   = stepIn;
        window_end    = (window_cnt_q == WIN_LAST);
        window_cnt_d  = window_cnt_q + 1'b1;
        if (window_end) begin
            window_cnt_d = '0;
        end
        second_tick_d = (window_cnt_d == WIN_LAST);
    end

    // A step landing on the tick edge is folded into the ending window
    always_comb begin
        per_sec_inc = per_sec_q;
        if (per_sec_q != 8'hFF) begin
            per_sec_inc = per_sec_q + 8'd1;
        end
        n_final = step_evt ? per_sec_inc : per_sec_q;
        per_sec_d = window_end ? 8'd0 : n_final;
    end

    // Lifetime step count and distance
    always_comb begin
        total_d = total_q;
        if (step_evt && (total_q < SAT)) begin
            total_d = total_q + 14'd1;
        end

        half_sub_d = half_sub_q;
        half_wrap  = 1'b0;
        if (step_evt) begin
            half_sub_d = half_sub_q + 1'b1;
            half_wrap  = &half_sub_q;
        end

        dist_d = dist_q;
        if (half_wrap && (dist_q < SAT)) begin
            dist_d = dist_q + 14'd1;
        end
    end

    // Per-window evaluation on the tick edge
    always_comb begin
        early_d   = early_q;
        fast_d    = fast_q;
        elapsed_d = elapsed_q;
        if (window_end) begin
            if ((elapsed_q < EARLY) && (n_final > RATE_LO)) begin
                early_d = early_q + 14'd1;
            end
            if ((n_final >= RATE_HI) && (fast_q < SAT)) begin
                fast_d = fast_q + 14'd1;
            end
            if (elapsed_q < EARLY) begin
                elapsed_d = elapsed_q + 4'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            step_prev_q   <= 1'b0;
            window_cnt_q  <= '0;
            second_tick_q <= 1'b0;
            per_sec_q     <= '0;
            half_sub_q    <= '0;
            elapsed_q     <= '0;
            total_q       <= '0;
            dist_q        <= '0;
            early_q       <= '0;
            fast_q        <= '0;
        end else begin
            step_prev_q   <= step_prev_d;
            window_cnt_q  <= window_cnt_d;
            second_tick_q <= second_tick_d;
            per_sec_q     <= per_sec_d;
            half_sub_q    <= half_sub_d;
            elapsed_q     <= elapsed_d;
            total_q       <= total_d;
            dist_q        <= dist_d;
            early_q       <= early_d;
            fast_q        <= fast_d;
        end
    end

    assign totalSteps              = total_q;
    assign distanceCovered         = dist_q;
    assign thirtyTwoStepsPerSecond = early_q;
    assign sixtyFourStepsPerSecond = fast_q;
    assign secondTick              = second_tick_q;

endmodule

// File: tb/tb_step_tracker.sv
// Directed bench for step_tracker: one instance with 200-cycle windows,
// one with 20-cycle windows and a 2-step half mile for saturation.
module tb_step_tracker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step_a = 1'b0;
    logic        step_b = 1'b0;

    logic [13:0] total_a, dist_a, t32_a, t64_a;
    logic [13:0] total_b, dist_b, t32_b, t64_b;
    logic        tick_a, tick_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    step_tracker #(.CLK_HZ(200)) dut_a (
        .CLK                     (clk),
        .RESET                   (rst),
        .stepIn                  (step_a),
        .totalSteps              (total_a),
        .distanceCovered         (dist_a),
        .thirtyTwoStepsPerSecond (t32_a),
        .sixtyFourStepsPerSecond (t64_a),
        .secondTick              (tick_a)
    );

    step_tracker #(.CLK_HZ(20), .STEPS_PER_HALF_MILE(2)) dut_b (
        .CLK                     (clk),
        .RESET                   (rst),
        .stepIn                  (step_b),
        .totalSteps              (total_b),
        .distanceCovered         (dist_b),
        .thirtyTwoStepsPerSecond (t32_b),
        .sixtyFourStepsPerSecond (t64_b),
        .secondTick              (tick_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step_a = 1'b0;
        step_b = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulses_a(input int n);
        for (int i = 0; i < n; i++) begin
            step_a = 1'b1;
            @(negedge clk);
            step_a = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pulses_b(input int n);
        for (int i = 0; i < n; i++) begin
            step_b = 1'b1;
            @(negedge clk);
            step_b = 1'b0;
            @(negedge clk);
        end
    endtask

    // Stop at the negedge preceding the tick edge (tick visible)
    task automatic sync_tick();
        int n;
        n = 0;
        while (tick_a !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("sync_tick", 32'(tick_a), 32'd1);
    endtask

    // Pass the tick edge so the next edge opens a fresh window
    task automatic window_a(input int n);
        pulses_a(n);
        sync_tick();
        @(negedge clk);
    endtask

    initial begin
        int ticks;
        int first;

        do_reset();
        chk("rst_total", 32'(total_a), 0);
        chk("rst_dist", 32'(dist_a), 0);
        chk("rst_t32", 32'(t32_a), 0);
        chk("rst_t64", 32'(t64_a), 0);
        chk("rst_tick", 32'(tick_a), 0);

        ticks = 0;
        first = 0;
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            if (tick_a) begin
                ticks++;
                if (first == 0) first = i;
            end
        end
        chk("idle_ticks", 32'(ticks), 5);
        chk("idle_first_tick", 32'(first), 199);
        chk("idle_total", 32'(total_a), 0);
        chk("idle_t32", 32'(t32_a), 0);
        chk("idle_t64", 32'(t64_a), 0);

        pulses_a(3);
        chk("pre_rst_total", 32'(total_a), 3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_total", 32'(total_a), 0);
        @(negedge clk);
        step_a = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("high_at_release", 32'(total_a), 1);
        step_a = 1'b0;
        @(negedge clk);

        do_reset();
        for (int i = 0; i < 1234; i++) begin
            step_a = 1'b1;
            @(negedge clk);
            step_a = 1'b0;
            repeat (2) @(negedge clk);
        end
        chk("edges_total", 32'(total_a), 1234);
        chk("edges_dist", 32'(dist_a), 1);
        step_a = 1'b1;
        repeat (50) @(negedge clk);
        step_a = 1'b0;
        repeat (2) @(negedge clk);
        chk("held_total", 32'(total_a), 1235);
        chk("held_dist", 32'(dist_a), 1);

        do_reset();
        window_a(32);
        chk("rate32_t32", 32'(t32_a), 0);
        window_a(33);
        chk("rate33_t32", 32'(t32_a), 1);
        window_a(63);
        chk("rate63_t64", 32'(t64_a), 0);
        window_a(64);
        chk("rate_t32", 32'(t32_a), 3);
        chk("rate_t64", 32'(t64_a), 1);

        do_reset();
        for (int w = 0; w < 12; w++) window_a(40);
        chk("early_t32", 32'(t32_a), 9);
        chk("early_t64", 32'(t64_a), 0);
        for (int w = 0; w < 3; w++) window_a(70);
        chk("late_t32", 32'(t32_a), 9);
        chk("late_t64", 32'(t64_a), 3);

        do_reset();
        pulses_a(63);
        sync_tick();
        step_a = 1'b1;
        @(negedge clk);
        step_a = 1'b0;
        chk("collide_t64", 32'(t64_a), 1);
        chk("collide_total", 32'(total_a), 64);
        @(negedge clk);
        window_a(63);
        chk("after_t64", 32'(t64_a), 1);
        chk("after_t32", 32'(t32_a), 2);
        chk("after_total", 32'(total_a), 127);

        do_reset();
        pulses_b(10050);
        chk("sat_total", 32'(total_b), 9999);
        chk("sat_dist", 32'(dist_b), 5025);
        chk("sat_t64", 32'(t64_b), 0);
        pulses_b(10);
        chk("sat_hold_total", 32'(total_b), 9999);
        chk("sat_more_dist", 32'(dist_b), 5030);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
